// File: rtl/pc_fetch_unit.sv
// Fetch PC register and Instr_Mem request generator for the RV32I front end.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned redirects into trap entry.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INC          = 4
) (
    input  logic            CLK,
    input  logic            nRESET,
    input  logic            hazard_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            req_ready_i,
    output logic            req_valid_o,
    output logic [XLEN-1:0] req_addr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            stale_o,
    output logic            misalign_o,
    output logic [1:0]      state_o,
    output logic            pend_v_o
);

    localparam logic [XLEN-1:0] INC_X = XLEN'(INC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend_pc;
    logic            pend_v;

    logic            accept;
    logic            misalign;
    logic            trap_eff;
    logic            redir_eff;
    logic            jump;
    logic [XLEN-1:0] jump_pc;

    // Handshake: a request is transferred on any edge where req_valid_o and
    // req_ready_i are both high; until then address and valid are held.
    assign accept = (state == FETCH) & req_ready_i;

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign = redirect_i & (redirect_pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A misaligned redirect is demoted to a trap towards trap_vec_i.
    assign trap_eff  = trap_i | misalign;
    assign redir_eff = redirect_i & ~misalign;
    assign jump      = trap_eff | redir_eff;
    assign jump_pc   = trap_eff ? trap_vec_i : redirect_pc_i;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= IDLE;
            pc      <= RESET_VECTOR;
            pend_pc <= '0;
            pend_v  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (jump) pc <= jump_pc;
                end
                FETCH: begin
                    if (accept) begin
                        if (jump)        pc <= jump_pc;
                        else if (pend_v) pc <= pend_pc;
                        else             pc <= pc + INC_X;
                        pend_v <= 1'b0;
                        state  <= hazard_i ? STALL : FETCH;
                    end else if (jump) begin
                        // Address must hold until accepted; remember the newest target.
                        pend_pc <= jump_pc;
                        pend_v  <= 1'b1;
                    end
                end
                STALL: begin
                    if (jump)      pc    <= jump_pc;
                    if (!hazard_i) state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_valid_o = (state == FETCH);
    assign req_addr_o  = pc;
    assign pc_o        = pc;
    assign pc_plus_o   = pc + INC_X;
    assign stale_o     = accept & (pend_v | trap_i | redirect_i);
    assign misalign_o  = misalign;
    assign state_o     = state;
    assign pend_v_o    = pend_v;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle reference model comparison
// plus directed scenarios with literal expected addresses.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        hazard_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        trap_i;
    logic [31:0] trap_vec_i;
    logic        req_ready_i;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_o;
    logic        stale_o;
    logic        misalign_o;
    logic [1:0]  state_o;
    logic        pend_v_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit dut (
        .CLK           (CLK),
        .nRESET        (nRESET),
        .hazard_i      (hazard_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .trap_i        (trap_i),
        .trap_vec_i    (trap_vec_i),
        .req_ready_i   (req_ready_i),
        .req_valid_o   (req_valid_o),
        .req_addr_o    (req_addr_o),
        .pc_o          (pc_o),
        .pc_plus_o     (pc_plus_o),
        .stale_o       (stale_o),
        .misalign_o    (misalign_o),
        .state_o       (state_o),
        .pend_v_o      (pend_v_o)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    logic [31:0] m_pc      = 32'h0;
    bit          m_started = 1'b0;
    bit          m_stalled = 1'b0;
    logic [31:0] pend_q[$];
    bit          m_trap;
    bit          m_redir;
    logic [31:0] m_tgt;

    function automatic bit m_valid();
        return m_started && !m_stalled;
    endfunction

    function automatic bit model_mis();
`ifdef PC_MISALIGN_TRAP_EN
        return redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            m_pc      = 32'h0;
            m_started = 1'b0;
            m_stalled = 1'b0;
            pend_q.delete();
        end else begin
            m_trap  = trap_i || model_mis();
            m_redir = redirect_i && !model_mis();
            m_tgt   = m_trap ? trap_vec_i : redirect_pc_i;
            if (!m_valid()) begin
                if (m_trap || m_redir) m_pc = m_tgt;
                if (!m_started)        m_started = 1'b1;
                else if (!hazard_i)    m_stalled = 1'b0;
            end else if (req_ready_i) begin
                if (m_trap || m_redir)      m_pc = m_tgt;
                else if (pend_q.size() > 0) m_pc = pend_q[$];
                else                        m_pc = m_pc + 32'd4;
                pend_q.delete();
                m_stalled = hazard_i;
            end else if (m_trap || m_redir) begin
                pend_q.push_back(m_tgt);
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        check("cmp_valid", {31'b0, req_valid_o}, {31'b0, m_valid()});
        check("cmp_addr", req_addr_o, m_pc);
        check("cmp_pc", pc_o, m_pc);
        check("cmp_pc_plus", pc_plus_o, m_pc + 32'd4);
        check("cmp_stale", {31'b0, stale_o},
              {31'b0, m_valid() && req_ready_i && (pend_q.size() > 0 || trap_i || redirect_i)});
        check("cmp_misalign", {31'b0, misalign_o}, {31'b0, model_mis()});
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    initial begin
        hazard_i      = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        trap_i        = 1'b0;
        trap_vec_i    = 32'h100;
        req_ready_i   = 1'b1;
        nRESET        = 1'b1;
        #1 nRESET     = 1'b0;
        repeat (2) tick();
        at_neg();
        check("rst_valid", {31'b0, req_valid_o}, 32'd0);
        check("rst_addr", req_addr_o, 32'h0);
        check("rst_stale", {31'b0, stale_o}, 32'd0);
        check("rst_misalign", {31'b0, misalign_o}, 32'd0);
        tick();
        nRESET = 1'b1;
        tick();

        // stream 0,4,8,12
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check("stream_valid", {31'b0, req_valid_o}, 32'd1);
            check("stream_addr", req_addr_o, 32'(k * 4));
            check("stream_stale", {31'b0, stale_o}, 32'd0);
            tick();
        end

        // backpressure at 0x10 with redirect in cycle 2
        req_ready_i = 1'b0;
        at_neg(); check("bp_hold1", req_addr_o, 32'h10);
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h80;
        at_neg(); check("bp_hold2", req_addr_o, 32'h10);
        tick();
        redirect_i = 1'b0;
        at_neg(); check("bp_hold3", req_addr_o, 32'h10);
        tick();
        req_ready_i = 1'b1;
        at_neg();
        check("bp_accept_addr", req_addr_o, 32'h10);
        check("bp_accept_stale", {31'b0, stale_o}, 32'd1);
        tick();
        at_neg();
        check("bp_next_addr", req_addr_o, 32'h80);
        check("bp_next_stale", {31'b0, stale_o}, 32'd0);

        // redirect with same-cycle accept, then hazard at 0x20
        redirect_i = 1'b1; redirect_pc_i = 32'h20;
        at_neg(); check("redir_accept_stale", {31'b0, stale_o}, 32'd1);
        tick();
        redirect_i = 1'b0;
        hazard_i   = 1'b1;
        at_neg(); check("hz_addr", req_addr_o, 32'h20);
        tick();
        at_neg(); check("hz_low1", {31'b0, req_valid_o}, 32'd0);
        tick();
        hazard_i = 1'b0;
        at_neg(); check("hz_low2", {31'b0, req_valid_o}, 32'd0);
        tick();
        at_neg();
        check("hz_resume_valid", {31'b0, req_valid_o}, 32'd1);
        check("hz_resume_addr", req_addr_o, 32'h24);

        // trap beats redirect in STALL
        hazard_i = 1'b1;
        tick();
        trap_i = 1'b1; trap_vec_i = 32'h100;
        redirect_i = 1'b1; redirect_pc_i = 32'h80;
        at_neg(); check("stall_stale", {31'b0, stale_o}, 32'd0);
        tick();
        trap_i = 1'b0; redirect_i = 1'b0;
        at_neg(); check("trap_pc", pc_o, 32'h100);
        hazard_i = 1'b0;
        tick();
        at_neg(); check("trap_fetch", req_addr_o, 32'h100);

        // wrap
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        at_neg();
        check("wrap_addr", req_addr_o, 32'hFFFF_FFFC);
        check("wrap_plus", pc_plus_o, 32'h0);
        tick();
        at_neg(); check("wrap_next", req_addr_o, 32'h0);

        // misaligned redirect
        redirect_i = 1'b1; redirect_pc_i = 32'h82; trap_vec_i = 32'h200;
        at_neg();
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_flag", {31'b0, misalign_o}, 32'd1);
`else
        check("mis_flag", {31'b0, misalign_o}, 32'd0);
`endif
        tick();
        redirect_i = 1'b0;
        at_neg();
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pc", pc_o, 32'h200);
`else
        check("mis_pc", pc_o, 32'h82);
`endif

        // later pending event overwrites earlier one
        req_ready_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        trap_i = 1'b1; trap_vec_i = 32'h300;
        tick();
        trap_i = 1'b0; req_ready_i = 1'b1;
        at_neg(); check("pend_stale", {31'b0, stale_o}, 32'd1);
        tick();
        at_neg(); check("pend_overwrite", req_addr_o, 32'h300);

        // reset while a request is outstanding with a pending redirect
        req_ready_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h44;
        tick();
        redirect_i = 1'b0;
        nRESET = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, req_valid_o}, 32'd0);
        check("async_rst_addr", req_addr_o, 32'h0);
        tick();
        nRESET = 1'b1; req_ready_i = 1'b1;
        tick();
        at_neg(); check("restart_addr0", req_addr_o, 32'h0);
        tick();
        at_neg(); check("restart_addr4", req_addr_o, 32'h4);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
